// File: rtl/image_line_writer.sv
// Writes one display line of background/mask pixels into SDRAM as interleaved 16-bit words.
// Each 24-bit pixel pair becomes three words {mask byte, bg byte}, low byte first.
// Optional feature: define IMAGE_LINE_WRITER_CHECKSUM_EN to add a 16-bit running sum of the
// written words on the checksum output.
module image_line_writer #(
    parameter int unsigned WIDTH      = 720,
    parameter int unsigned HEIGHT     = 720,
    parameter int unsigned ADDR_WIDTH = 25
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [9:0]            line_y,
    output logic                  busy,
    output logic                  line_done,
    output logic                  error,
    input  logic                  pixel_valid,
    output logic                  pixel_ready,
    input  logic [23:0]           bg_pixel,
    input  logic [23:0]           mask_pixel,
    output logic [ADDR_WIDTH-1:0] sd_addr,
    output logic [15:0]           sd_data,
    output logic                  sd_wr_req,
    input  logic                  sd_wr_ack
`ifdef IMAGE_LINE_WRITER_CHECKSUM_EN
    ,
    output logic [15:0]           checksum
`endif
);

    localparam int unsigned           PixW      = $clog2(WIDTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LineWords = ADDR_WIDTH'(WIDTH * 3);
    localparam logic [PixW-1:0]       LastPix   = PixW'(WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StAccept, StWrite, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PixW-1:0]       pix_q, pix_d;
    logic [1:0]            k_q, k_d;
    logic [23:0]           bg_q, bg_d;
    logic [23:0]           mask_q, mask_d;
    logic                  error_q, error_d;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            line_addr_q <= '0;
            addr_q      <= '0;
            pix_q       <= '0;
            k_q         <= '0;
            bg_q        <= '0;
            mask_q      <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            addr_q      <= addr_d;
            pix_q       <= pix_d;
            k_q         <= k_d;
            bg_q        <= bg_d;
            mask_q      <= mask_d;
            error_q     <= error_d;
        end
    end

    // Next-state logic: line setup, pixel acceptance and the three-word write sequence.
    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        addr_d      = addr_q;
        pix_d       = pix_q;
        k_d         = k_q;
        bg_d        = bg_q;
        mask_d      = mask_q;
        error_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (32'(line_y) < HEIGHT) begin
                        line_addr_d = base_addr + ADDR_WIDTH'(line_y) * LineWords;
                        state_d     = StSetup;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            StSetup: begin
                addr_d  = line_addr_q;
                pix_d   = '0;
                state_d = StAccept;
            end
            StAccept: begin
                if (pixel_valid) begin
                    bg_d    = bg_pixel;
                    mask_d  = mask_pixel;
                    k_d     = 2'd0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (sd_wr_ack) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (k_q == 2'd2) begin
                        k_d     = 2'd0;
                        pix_d   = pix_q + PixW'(1);
                        state_d = (pix_q == LastPix) ? StDone : StAccept;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode straight from state so reset drops req/ready without waiting for a clock.
    always_comb begin
        busy        = (state_q == StSetup) || (state_q == StAccept) || (state_q == StWrite);
        pixel_ready = (state_q == StAccept);
        sd_wr_req   = (state_q == StWrite);
        line_done   = (state_q == StDone);
        error       = error_q;
        sd_addr     = addr_q;
        case (k_q)
            2'd0:    sd_data = {mask_q[7:0], bg_q[7:0]};
            2'd1:    sd_data = {mask_q[15:8], bg_q[15:8]};
            2'd2:    sd_data = {mask_q[23:16], bg_q[23:16]};
            default: sd_data = 16'h0000;
        endcase
    end

`ifdef IMAGE_LINE_WRITER_CHECKSUM_EN
    logic [15:0] checksum_q;

    // Running sum of acked words; cleared per line, held after line_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum_q <= 16'h0000;
        end else if (state_q == StSetup) begin
            checksum_q <= 16'h0000;
        end else if ((state_q == StWrite) && sd_wr_ack) begin
            checksum_q <= checksum_q + sd_data;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_image_line_writer.sv
// Directed self-checking bench for image_line_writer (WIDTH=4, HEIGHT=720).
module tb_image_line_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [24:0] base_addr;
    logic [9:0]  line_y;
    logic        busy, line_done, error;
    logic        pixel_valid, pixel_ready;
    logic [23:0] bg_pixel, mask_pixel;
    logic [24:0] sd_addr;
    logic [15:0] sd_data;
    logic        sd_wr_req, sd_wr_ack;
`ifdef IMAGE_LINE_WRITER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    image_line_writer #(.WIDTH(4), .HEIGHT(720), .ADDR_WIDTH(25)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .line_y     (line_y),
        .busy       (busy),
        .line_done  (line_done),
        .error      (error),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .bg_pixel   (bg_pixel),
        .mask_pixel (mask_pixel),
        .sd_addr    (sd_addr),
        .sd_data    (sd_data),
        .sd_wr_req  (sd_wr_req),
        .sd_wr_ack  (sd_wr_ack)
`ifdef IMAGE_LINE_WRITER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    int asserts = 0;
    int fails   = 0;

    logic [24:0] wr_addr [$];
    logic [15:0] wr_data [$];
    int          done_cnt, done_busy, err_cnt, rdy_viol, stall_bad, stall_seen;
    logic [24:0] hold_a;
    logic [15:0] hold_d;
    logic [23:0] px_bg   [4];
    logic [23:0] px_mask [4];

    // Mid-cycle monitor: a write happens at the next posedge when req and ack are both high.
    always @(negedge clk) begin
        if (sd_wr_req && sd_wr_ack) begin
            wr_addr.push_back(sd_addr);
            wr_data.push_back(sd_data);
        end
        if (line_done) begin
            done_cnt++;
            if (busy) done_busy++;
        end
        if (error) err_cnt++;
        if (sd_wr_req && pixel_ready) rdy_viol++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one line; optional ack stall at a word index, optional early return at a word index.
    task automatic run_line(input logic [24:0] base, input logic [9:0] y, input int stall_at,
                            input int abort_at, input bit busy_start);
        int idx = 0;
        bit acc;
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0; done_busy = 0; err_cnt = 0; rdy_viol = 0; stall_bad = 0; stall_seen = 0;
        base_addr = base; line_y = y; start = 1'b1;
        tick();
        start = 1'b0;
        if (busy_start) begin
            line_y = 10'd720; start = 1'b1;
            tick();
            start = 1'b0; line_y = y;
        end
        bg_pixel = px_bg[0]; mask_pixel = px_mask[0]; pixel_valid = 1'b1; sd_wr_ack = 1'b1;
        for (int c = 0; c < 300 && done_cnt == 0; c++) begin
            if (abort_at >= 0 && wr_addr.size() == abort_at && sd_wr_req) return;
            if (stall_at >= 0 && wr_addr.size() == stall_at && sd_wr_req && stall_seen < 5) begin
                if (stall_seen == 0) begin
                    hold_a = sd_addr; hold_d = sd_data;
                end else if (sd_addr !== hold_a || sd_data !== hold_d) begin
                    stall_bad++;
                end
                sd_wr_ack = 1'b0;
                stall_seen++;
            end else begin
                sd_wr_ack = 1'b1;
            end
            acc = pixel_valid && pixel_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    bg_pixel = px_bg[idx]; mask_pixel = px_mask[idx];
                end else begin
                    pixel_valid = 1'b0;
                end
            end
        end
        sd_wr_ack = 1'b0; pixel_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; base_addr = '0; line_y = '0; pixel_valid = 1'b0;
        bg_pixel = '0; mask_pixel = '0; sd_wr_ack = 1'b0;
        tick();
        tick();
        asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        asserts++; if (line_done !== 1'b0) begin fails++; $display("FAIL reset_line_done: got %b expected 0", line_done); end
        asserts++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b expected 0", error); end
        asserts++; if (pixel_ready !== 1'b0) begin fails++; $display("FAIL reset_pixel_ready: got %b expected 0", pixel_ready); end
        asserts++; if (sd_wr_req !== 1'b0) begin fails++; $display("FAIL reset_sd_wr_req: got %b expected 0", sd_wr_req); end
        asserts++; if (sd_addr !== 25'h0) begin fails++; $display("FAIL reset_sd_addr: got %h expected 0", sd_addr); end
        asserts++; if (sd_data !== 16'h0) begin fails++; $display("FAIL reset_sd_data: got %h expected 0", sd_data); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_line();
        logic [15:0] exp_d;
        int p, k;
        px_bg[0] = 24'h112233; px_mask[0] = 24'hAABBCC;
        px_bg[1] = 24'h445566; px_mask[1] = 24'hDDEEFF;
        px_bg[2] = 24'h778899; px_mask[2] = 24'h102030;
        px_bg[3] = 24'hA0B0C0; px_mask[3] = 24'h0F1E2D;
        run_line(25'h100, 10'd2, -1, -1, 1'b0);
        asserts++; if (wr_addr.size() != 12) begin fails++; $display("FAIL basic_count: got %0d expected 12", wr_addr.size()); end
        for (int i = 0; i < 12 && i < wr_addr.size(); i++) begin
            p = i / 3; k = i % 3;
            exp_d = {px_mask[p][8*k +: 8], px_bg[p][8*k +: 8]};
            asserts++; if (wr_addr[i] !== 25'h118 + 25'(i)) begin fails++; $display("FAIL basic_addr[%0d]: got %h expected %h", i, wr_addr[i], 25'h118 + 25'(i)); end
            asserts++; if (wr_data[i] !== exp_d) begin fails++; $display("FAIL basic_data[%0d]: got %h expected %h", i, wr_data[i], exp_d); end
        end
        asserts++; if (done_cnt != 1) begin fails++; $display("FAIL basic_line_done: got %0d pulses expected 1", done_cnt); end
        asserts++; if (done_busy != 0) begin fails++; $display("FAIL basic_busy_at_done: got %0d expected 0", done_busy); end
        asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_byte_packing();
        px_bg[0] = 24'h112233; px_mask[0] = 24'hAABBCC;
        for (int i = 1; i < 4; i++) begin px_bg[i] = 24'h0; px_mask[i] = 24'h0; end
        run_line(25'h200, 10'd0, -1, -1, 1'b0);
        asserts++; if (wr_addr.size() != 12) begin fails++; $display("FAIL pack_count: got %0d expected 12", wr_addr.size()); end
        if (wr_addr.size() >= 3) begin
            asserts++; if (wr_data[0] !== 16'hCC33) begin fails++; $display("FAIL pack_w0: got %h expected cc33", wr_data[0]); end
            asserts++; if (wr_data[1] !== 16'hBB22) begin fails++; $display("FAIL pack_w1: got %h expected bb22", wr_data[1]); end
            asserts++; if (wr_data[2] !== 16'hAA11) begin fails++; $display("FAIL pack_w2: got %h expected aa11", wr_data[2]); end
            asserts++; if (wr_addr[2] !== 25'h202) begin fails++; $display("FAIL pack_a2: got %h expected 202", wr_addr[2]); end
        end
    endtask

    task automatic test_stall();
        px_bg[0] = 24'h010101; px_mask[0] = 24'h020202;
        px_bg[1] = 24'h332211; px_mask[1] = 24'h665544;
        px_bg[2] = 24'h030303; px_mask[2] = 24'h040404;
        px_bg[3] = 24'h050505; px_mask[3] = 24'h060606;
        run_line(25'h100, 10'd1, 4, -1, 1'b0);
        asserts++; if (stall_seen != 5) begin fails++; $display("FAIL stall_cycles: got %0d expected 5", stall_seen); end
        asserts++; if (hold_a !== 25'h110) begin fails++; $display("FAIL stall_addr: got %h expected 110", hold_a); end
        asserts++; if (hold_d !== 16'h5522) begin fails++; $display("FAIL stall_data: got %h expected 5522", hold_d); end
        asserts++; if (stall_bad != 0) begin fails++; $display("FAIL stall_stable: got %0d changes expected 0", stall_bad); end
        asserts++; if (rdy_viol != 0) begin fails++; $display("FAIL stall_ready_in_write: got %0d expected 0", rdy_viol); end
        asserts++; if (wr_addr.size() != 12) begin fails++; $display("FAIL stall_count: got %0d expected 12", wr_addr.size()); end
        for (int i = 0; i < 12 && i < wr_addr.size(); i++) begin
            asserts++; if (wr_addr[i] !== 25'h10C + 25'(i)) begin fails++; $display("FAIL stall_addr[%0d]: got %h expected %h", i, wr_addr[i], 25'h10C + 25'(i)); end
        end
        asserts++; if (wr_data.size() > 5 && wr_data[5] !== 16'h6633) begin fails++; $display("FAIL stall_w5: got %h expected 6633", wr_data[5]); end
    endtask

    task automatic test_bad_line();
        wr_addr.delete();
        base_addr = 25'h100; line_y = 10'd720; start = 1'b1;
        tick();
        start = 1'b0;
        asserts++; if (error !== 1'b1) begin fails++; $display("FAIL bad_error_pulse: got %b expected 1", error); end
        asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL bad_busy: got %b expected 0", busy); end
        tick();
        asserts++; if (error !== 1'b0) begin fails++; $display("FAIL bad_error_width: got %b expected 0", error); end
        tick();
        asserts++; if (wr_addr.size() != 0) begin fails++; $display("FAIL bad_writes: got %0d expected 0", wr_addr.size()); end
        // Last valid line, with a bad start during SETUP that must be ignored.
        run_line(25'h0, 10'd719, -1, -1, 1'b1);
        asserts++; if (err_cnt != 0) begin fails++; $display("FAIL busy_start_error: got %0d expected 0", err_cnt); end
        asserts++; if (wr_addr.size() != 12) begin fails++; $display("FAIL y719_count: got %0d expected 12", wr_addr.size()); end
        asserts++; if (wr_addr.size() > 0 && wr_addr[0] !== 25'h21B4) begin fails++; $display("FAIL y719_addr: got %h expected 21b4", wr_addr[0]); end
    endtask

    task automatic test_wrap();
        run_line(25'h1FFFFFF, 10'd0, -1, -1, 1'b0);
        asserts++; if (wr_addr.size() != 12) begin fails++; $display("FAIL wrap_count: got %0d expected 12", wr_addr.size()); end
        if (wr_addr.size() == 12) begin
            asserts++; if (wr_addr[1] !== 25'h0) begin fails++; $display("FAIL wrap_a1: got %h expected 0", wr_addr[1]); end
            asserts++; if (wr_addr[11] !== 25'hA) begin fails++; $display("FAIL wrap_a11: got %h expected a", wr_addr[11]); end
        end
    endtask

    task automatic test_reset_mid_line();
        run_line(25'h100, 10'd2, -1, 1, 1'b0);
        asserts++; if (sd_wr_req !== 1'b1) begin fails++; $display("FAIL midrst_pre_req: got %b expected 1", sd_wr_req); end
        asserts++; if (wr_addr.size() != 1) begin fails++; $display("FAIL midrst_pre_count: got %0d expected 1", wr_addr.size()); end
        reset = 1'b1;
        #1;
        asserts++; if (sd_wr_req !== 1'b0) begin fails++; $display("FAIL midrst_req: got %b expected 0", sd_wr_req); end
        asserts++; if (pixel_ready !== 1'b0) begin fails++; $display("FAIL midrst_ready: got %b expected 0", pixel_ready); end
        asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        sd_wr_ack = 1'b0; pixel_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_idle: got %b expected 0", busy); end
        run_line(25'h100, 10'd2, -1, -1, 1'b0);
        asserts++; if (wr_addr.size() != 12) begin fails++; $display("FAIL midrst_count: got %0d expected 12", wr_addr.size()); end
        for (int i = 0; i < 12 && i < wr_addr.size(); i++) begin
            asserts++; if (wr_addr[i] !== 25'h118 + 25'(i)) begin fails++; $display("FAIL midrst_addr[%0d]: got %h expected %h", i, wr_addr[i], 25'h118 + 25'(i)); end
        end
        asserts++; if (done_cnt != 1) begin fails++; $display("FAIL midrst_done: got %0d expected 1", done_cnt); end
    endtask

`ifdef IMAGE_LINE_WRITER_CHECKSUM_EN
    task automatic test_checksum();
        for (int i = 0; i < 4; i++) begin px_bg[i] = 24'h010203; px_mask[i] = 24'h000000; end
        run_line(25'h100, 10'd2, -1, -1, 1'b0);
        asserts++; if (checksum !== 16'h0018) begin fails++; $display("FAIL checksum: got %h expected 0018", checksum); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_line();
        test_byte_packing();
        test_stall();
        test_bad_line();
        test_wrap();
        test_reset_mid_line();
`ifdef IMAGE_LINE_WRITER_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/image_line_writer.md
Name: image_line_writer

Overview:
- Writes one display line of background and mask image data into SDRAM in the interleaved layout that the video line reader consumes.
- Each 24-bit pixel pair is split into three 16-bit words: background byte in [7:0], mask byte in [15:8].
- Sits between an image source (loader or generated pattern) and the SDRAM write port.
- Computes line base addresses and drives a request/acknowledge write handshake.

Parameters:
- WIDTH, 720, pixels per line.
- HEIGHT, 720, number of valid lines; any line_y >= HEIGHT is rejected.
- ADDR_WIDTH, 25, SDRAM word address width.

Ports:
- clk  input  1  system clock; the single clock for all logic.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a line; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  word address of line 0, pixel 0.
- line_y  input  10  line number to write; sampled with start.
- busy  output  1  high from the cycle after an accepted start until line_done.
- line_done  output  1  one-cycle pulse after the final word of the line is acked.
- error  output  1  one-cycle pulse when start arrives with line_y >= HEIGHT.
- pixel_valid  input  1  source holds a pixel.
- pixel_ready  output  1  block can accept a pixel.
- bg_pixel  input  24  background pixel.
- mask_pixel  input  24  mask pixel.
- sd_addr  output  ADDR_WIDTH  SDRAM word address.
- sd_data  output  16  SDRAM write data.
- sd_wr_req  output  1  write request, level-held.
- sd_wr_ack  input  1  SDRAM accepted the current word.

Behaviour:
- Reset values: state IDLE; all outputs 0; pixel counter 0; word index 0.
- Reset is asynchronous. Asserting it mid-line drops sd_wr_req and pixel_ready immediately. The partially written line is not completed.
- State machine: IDLE, SETUP, ACCEPT, WRITE, DONE.
- IDLE:
  - On start with line_y < HEIGHT: latch base_addr + line_y*WIDTH*3, truncated to ADDR_WIDTH, and go to SETUP.
  - On start with line_y >= HEIGHT: pulse error for 1 cycle and stay in IDLE.
- SETUP: load the word address register from the latched value, clear the pixel counter and go to ACCEPT. This is one cycle, so pixel_ready rises 2 cycles after start.
- Starts received outside IDLE are ignored; they raise no error.
- ACCEPT:
  - pixel_ready = 1.
  - On pixel_valid & pixel_ready: latch both pixels, set word index k = 0 and go to WRITE. sd_wr_req rises the next cycle.
- WRITE:
  - sd_wr_req = 1 with sd_addr = current word address and sd_data = {mask_pixel[8k+7:8k], bg_pixel[8k+7:8k]}. Address and data stay stable until ack.
  - On sd_wr_ack: increment the word address and k.
  - If k was 0 or 1, the next word is presented the following cycle and req stays high, so back-to-back writes are allowed.
  - If k was 2: increment the pixel counter. If the counter reaches WIDTH, go to DONE; otherwise go to ACCEPT with req low.
- sd_wr_ack sampled while sd_wr_req = 0 is ignored.
- DONE: pulse line_done for 1 cycle, drop busy and return to IDLE.
- A line always occupies exactly WIDTH*3 consecutive word addresses. Word address arithmetic wraps modulo 2^ADDR_WIDTH with no error.
- busy = 1 in SETUP, ACCEPT and WRITE, and 0 in IDLE and DONE.

Optional Feature:
- Macro: IMAGE_LINE_WRITER_CHECKSUM_EN.
- When defined:
  - Extra output port checksum, 16 bits.
  - The checksum is cleared in SETUP.
  - On every acked word, checksum <= checksum + sd_data, modulo 2^16.
  - The value is valid and held from line_done until the next SETUP.
- When undefined: the port and the adder are absent and behaviour is otherwise identical.

Test Plan:
- Basic line: WIDTH=4, base_addr=0x100, line_y=2, 4 pixels. Ack on every req cycle. The 12 writes go to 0x118..0x123 and line_done pulses once.
- Byte packing: bg 0x112233 and mask 0xAABBCC. Data words are 0xCC33, 0xBB22, 0xAA11 in order at consecutive addresses.
- Handshake stall: ack held low for 5 cycles mid-word. sd_addr and sd_data stay stable, there is no duplicate or skipped word, and pixel_ready stays 0 throughout WRITE.
- Bad line: start with line_y=720 at HEIGHT=720. error pulses for 1 cycle, busy stays 0 and there are no writes. Start while busy is ignored.
- Reset mid-line: assert reset during k=1. sd_wr_req drops in the same cycle and the state is IDLE. A following start writes the full line correctly.
- Checksum (macro defined): the basic-line stimulus with all pixels bg 0x010203 and mask 0x000000. checksum = 4*(0x0003+0x0002+0x0001) = 0x0018 at line_done.
